// File: rtl/id_stage_pkg.sv
// Shared decode constants for the ID stage: instruction modes, opcodes,
// execute-unit commands, condition codes and the NZCV condition evaluator.
package id_stage_pkg;

    localparam logic [1:0] MODE_DP  = 2'b00;
    localparam logic [1:0] MODE_MEM = 2'b01;
    localparam logic [1:0] MODE_BR  = 2'b10;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_MVN = 4'b1111;

    localparam logic [3:0] CMD_NOP = 4'b0000;
    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;
    localparam logic [3:0] CMD_MVN = 4'b1001;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    typedef struct packed {
        logic wb_en;
        logic mem_r_en;
        logic mem_w_en;
        logic b;
        logic s;
    } ctrl_t;

    // sr is {N, Z, C, V}; code 1111 (never) falls to the default.
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] sr);
        logic n, z, c, v;
        n = sr[3];
        z = sr[2];
        c = sr[1];
        v = sr[0];
        case (cond)
            COND_EQ: return z;
            COND_NE: return !z;
            COND_CS: return c;
            COND_CC: return !c;
            COND_MI: return n;
            COND_PL: return !n;
            COND_VS: return v;
            COND_VC: return !v;
            COND_HI: return c && !z;
            COND_LS: return !c || z;
            COND_GE: return n == v;
            COND_LT: return n != v;
            COND_GT: return !z && (n == v);
            COND_LE: return z || (n != v);
            COND_AL: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/id_stage_register_file.sv
// 16x32 register file: two combinational read ports, one write port, with
// write-through bypass so a same-cycle read of the write address sees wdata.
module register_file (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  raddr1,
    input  logic [3:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    input  logic        we,
    input  logic [3:0]  waddr,
    input  logic [31:0] wdata
);

    logic [31:0] regs [16];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 16; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = (we && (waddr == raddr1)) ? wdata : regs[raddr1];
    assign rdata2 = (we && (waddr == raddr2)) ? wdata : regs[raddr2];

endmodule

// File: rtl/id_stage.sv
// Instruction decode stage: decode, condition check, hazard detection and the
// ID/EX pipeline register. Define FORWARDING_EN to stall only on load-use.
module id_stage
    import id_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    input  logic [31:0] pc,
    input  logic [3:0]  sr,
    input  logic        flush,
    input  logic        wb_wb_en,
    input  logic [3:0]  wb_dest,
    input  logic [31:0] wb_value,
    input  logic        exe_wb_en,
    input  logic [3:0]  exe_dest,
    input  logic        exe_mem_r_en,
    input  logic        mem_wb_en,
    input  logic [3:0]  mem_dest,
    output logic        ex_wb_en,
    output logic        ex_mem_r_en,
    output logic        ex_mem_w_en,
    output logic        ex_b,
    output logic        ex_s,
    output logic        ex_imm,
    output logic [3:0]  ex_exe_cmd,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_val_rn,
    output logic [31:0] ex_val_rm,
    output logic [11:0] ex_shift_operand,
    output logic [23:0] ex_signed_imm_24,
    output logic [3:0]  ex_dest,
    output logic [3:0]  ex_src1,
    output logic [3:0]  ex_src2,
    output logic        ex_c,
    output logic        hazard
);

    logic [1:0]  mode;
    logic [3:0]  opcode, rn, rd, rm, src2;
    logic        s_bit, i_bit;
    logic [3:0]  exe_cmd;
    ctrl_t       ctrl, ctrl_q;
    logic        uses_src1, uses_src2;
    logic        exe_hit, bubble;
    logic [31:0] val_rn, val_rm;

    assign mode   = instruction[27:26];
    assign opcode = instruction[24:21];
    assign s_bit  = instruction[20];
    assign i_bit  = instruction[25];
    assign rn     = instruction[19:16];
    assign rd     = instruction[15:12];
    assign rm     = instruction[3:0];

    always_comb begin
        exe_cmd   = CMD_NOP;
        ctrl      = '0;
        uses_src1 = 1'b1;
        uses_src2 = 1'b0;
        case (mode)
            MODE_DP: begin
                ctrl.wb_en = 1'b1;
                ctrl.s     = s_bit;
                uses_src2  = !i_bit;
                case (opcode)
                    OP_MOV: begin exe_cmd = CMD_MOV; uses_src1 = 1'b0; end
                    OP_MVN: begin exe_cmd = CMD_MVN; uses_src1 = 1'b0; end
                    OP_ADD: exe_cmd = CMD_ADD;
                    OP_ADC: exe_cmd = CMD_ADC;
                    OP_SUB: exe_cmd = CMD_SUB;
                    OP_SBC: exe_cmd = CMD_SBC;
                    OP_AND: exe_cmd = CMD_AND;
                    OP_ORR: exe_cmd = CMD_ORR;
                    OP_EOR: exe_cmd = CMD_EOR;
                    OP_CMP: begin exe_cmd = CMD_SUB; ctrl.wb_en = 1'b0; end
                    OP_TST: begin exe_cmd = CMD_AND; ctrl.wb_en = 1'b0; end
                    default: exe_cmd = CMD_NOP;
                endcase
            end
            MODE_MEM: begin
                exe_cmd       = CMD_ADD;
                ctrl.wb_en    = s_bit;
                ctrl.mem_r_en = s_bit;
                ctrl.mem_w_en = !s_bit;
                uses_src2     = !s_bit;
            end
            MODE_BR: begin
                ctrl.b    = 1'b1;
                uses_src1 = 1'b0;
            end
            default: ;
        endcase
    end

    // Stores read the data register through the second port.
    assign src2 = ctrl.mem_w_en ? rd : rm;

    assign exe_hit = (uses_src1 && (exe_dest == rn)) || (uses_src2 && (exe_dest == src2));

`ifdef FORWARDING_EN
    logic [4:0] unused_mem;
    assign unused_mem = {mem_wb_en, mem_dest};
    assign hazard = exe_mem_r_en && exe_wb_en && exe_hit;
`else
    logic unused_fwd;
    assign unused_fwd = exe_mem_r_en;
    assign hazard = (exe_wb_en && exe_hit) ||
                    (mem_wb_en && ((uses_src1 && (mem_dest == rn)) ||
                                   (uses_src2 && (mem_dest == src2))));
`endif

    assign bubble = flush || hazard || !cond_pass(instruction[31:28], sr);
    assign ctrl_q = bubble ? '0 : ctrl;

    register_file u_register_file (
        .clk    (clk),
        .rst    (rst),
        .raddr1 (rn),
        .raddr2 (src2),
        .rdata1 (val_rn),
        .rdata2 (val_rm),
        .we     (wb_wb_en),
        .waddr  (wb_dest),
        .wdata  (wb_value)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_wb_en         <= 1'b0;
            ex_mem_r_en      <= 1'b0;
            ex_mem_w_en      <= 1'b0;
            ex_b             <= 1'b0;
            ex_s             <= 1'b0;
            ex_imm           <= 1'b0;
            ex_exe_cmd       <= '0;
            ex_pc            <= '0;
            ex_val_rn        <= '0;
            ex_val_rm        <= '0;
            ex_shift_operand <= '0;
            ex_signed_imm_24 <= '0;
            ex_dest          <= '0;
            ex_src1          <= '0;
            ex_src2          <= '0;
            ex_c             <= 1'b0;
        end else begin
            ex_wb_en         <= ctrl_q.wb_en;
            ex_mem_r_en      <= ctrl_q.mem_r_en;
            ex_mem_w_en      <= ctrl_q.mem_w_en;
            ex_b             <= ctrl_q.b;
            ex_s             <= ctrl_q.s;
            ex_imm           <= i_bit;
            ex_exe_cmd       <= exe_cmd;
            ex_pc            <= pc;
            ex_val_rn        <= val_rn;
            ex_val_rm        <= val_rm;
            ex_shift_operand <= instruction[11:0];
            ex_signed_imm_24 <= instruction[23:0];
            ex_dest          <= rd;
            ex_src1          <= rn;
            ex_src2          <= src2;
            ex_c             <= sr[1];
        end
    end

endmodule
